// File: rtl/beat_pkg.sv
// rtl/beat_pkg.sv - beat and phase encodings plus the per-beat decision function
package beat_pkg;

   typedef enum logic [1:0] {HALT, W1, W2, W3} beat_state_t;
   typedef enum logic [1:0] {PH_T1, PH_T2, PH_T3} beat_phase_t;

   typedef struct packed {
      beat_state_t next;
      logic        end_of_instr;
   } beat_decision_t;

   // Beat that follows the current one, ignoring stop/single overrides.
   function automatic beat_decision_t next_beat(
      input beat_state_t state,
      input logic        short_req,
      input logic        long_req
   );
      beat_decision_t d;
      d.next         = HALT;
      d.end_of_instr = 1'b0;
      case (state)
         W1: begin
            if (short_req) begin
               d.next         = W1;
               d.end_of_instr = 1'b1;
            end else begin
               d.next = W2;
            end
         end
         W2: begin
            if (long_req) begin
               d.next = W3;
            end else begin
               d.next         = W1;
               d.end_of_instr = 1'b1;
            end
         end
         W3: begin
            d.next         = W1;
            d.end_of_instr = 1'b1;
         end
         default: begin
            d.next         = HALT;
            d.end_of_instr = 1'b0;
         end
      endcase
      return d;
   endfunction

endpackage

// File: rtl/qd_edge.sv
// rtl/qd_edge.sv - start button synchroniser with rising-edge pulse
module qd_edge (
   input  logic clk,
   input  logic clr,
   input  logic qd,
   output logic start
);

   logic sync1;
   logic sync2;
   logic delay;

   always_ff @(posedge clk) begin
      if (clr) begin
         sync1 <= 1'b0;
         sync2 <= 1'b0;
         delay <= 1'b0;
      end else begin
         sync1 <= qd;
         sync2 <= sync1;
         delay <= sync2;
      end
   end

   assign start = sync2 & ~delay;

endmodule

// File: rtl/beat_gen.sv
// rtl/beat_gen.sv - machine-cycle beat sequencer: W1/W2/W3 beats, t1..t3 phases
import beat_pkg::*;

module beat_gen #(
   parameter int CNT_W = 16
) (
   input  logic             clk,
   input  logic             clr,
   input  logic             qd,
   input  logic             short,
   input  logic             long,
   input  logic             stop,
   input  logic             single,
   output logic             t1,
   output logic             t2,
   output logic             t3,
   output logic             w1,
   output logic             w2,
   output logic             w3,
   output logic             running,
   output logic             instr_done,
   output logic [CNT_W-1:0] beat_cnt
);

   beat_state_t    state;
   beat_phase_t    phase;
   beat_decision_t dec;
   logic           start;

   qd_edge u_qd_edge (
      .clk   (clk),
      .clr   (clr),
      .qd    (qd),
      .start (start)
   );

   assign dec = next_beat(state, short, long);

   always_ff @(posedge clk) begin
      if (clr) begin
         state    <= HALT;
         phase    <= PH_T1;
         beat_cnt <= '0;
      end else if (state == HALT) begin
         // A start edge arriving while running is deliberately dropped.
         if (start) begin
            state <= W1;
            phase <= PH_T1;
         end
      end else begin
         case (phase)
            PH_T1: phase <= PH_T2;
            PH_T2: phase <= PH_T3;
            PH_T3: begin
               phase    <= PH_T1;
               beat_cnt <= beat_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
               if (stop || (single && dec.end_of_instr))
                  state <= HALT;
               else
                  state <= dec.next;
            end
            default: phase <= PH_T1;
         endcase
      end
   end

   assign running    = (state != HALT);
   assign w1         = (state == W1);
   assign w2         = (state == W2);
   assign w3         = (state == W3);
   assign t1         = running && (phase == PH_T1);
   assign t2         = running && (phase == PH_T2);
   assign t3         = running && (phase == PH_T3);
   assign instr_done = t3 && dec.end_of_instr;

endmodule

// File: tb/tb_beat_gen.sv
// tb/tb_beat_gen.sv - directed self-checking bench for beat_gen
module tb_beat_gen;

   logic       clk = 1'b0;
   logic       clr = 1'b1;
   logic       qd = 1'b0;
   logic       short = 1'b0;
   logic       long = 1'b0;
   logic       stop = 1'b0;
   logic       single = 1'b0;
   logic       t1, t2, t3, w1, w2, w3, running, instr_done;
   logic [3:0] beat_cnt;
   logic [7:0] obs;

   int asserts = 0;
   int failures = 0;

   always #5 clk = ~clk;

   beat_gen #(.CNT_W(4)) dut (
      .clk        (clk),
      .clr        (clr),
      .qd         (qd),
      .short      (short),
      .long       (long),
      .stop       (stop),
      .single     (single),
      .t1         (t1),
      .t2         (t2),
      .t3         (t3),
      .w1         (w1),
      .w2         (w2),
      .w3         (w3),
      .running    (running),
      .instr_done (instr_done),
      .beat_cnt   (beat_cnt)
   );

   assign obs = {w1, w2, w3, t1, t2, t3, running, instr_done};

   // w: 0 = halted, 1..3 = beat; ph: 1..3 = phase
   function automatic logic [7:0] exp_vec(input int w, input int ph, input logic done);
      logic [7:0] v;
      v = '0;
      if (w != 0) begin
         v[8-w]  = 1'b1;
         v[5-ph] = 1'b1;
         v[1]    = 1'b1;
      end
      v[0] = done;
      return v;
   endfunction

   task automatic test_reset();
      clr = 1'b1;
      repeat (2) @(negedge clk);
      asserts++;
      if (obs !== 8'h00) begin
         $display("FAIL reset_outputs: got %b want %b", obs, 8'h00);
         failures++;
      end
      asserts++;
      if (beat_cnt !== 4'd0) begin
         $display("FAIL reset_cnt: got %0d want 0", beat_cnt);
         failures++;
      end
      clr = 1'b0;
      repeat (3) @(negedge clk);
      asserts++;
      if (obs !== 8'h00) begin
         $display("FAIL halt_idle: got %b want %b", obs, 8'h00);
         failures++;
      end
   endtask

   task automatic test_normal();
      logic [7:0] e;
      qd = 1'b1;
      for (int i = 0; i < 2; i++) begin
         @(negedge clk);
         asserts++;
         if (running !== 1'b0) begin
            $display("FAIL start_latency cyc %0d: got running=%b want 0", i, running);
            failures++;
         end
      end
      @(negedge clk);
      qd = 1'b0;
      for (int i = 0; i < 6; i++) begin
         e = exp_vec(i < 3 ? 1 : 2, (i % 3) + 1, i == 5);
         asserts++;
         if (obs !== e) begin
            $display("FAIL normal cyc %0d: got %b want %b", i, obs, e);
            failures++;
         end
         @(negedge clk);
      end
      asserts++;
      if (beat_cnt !== 4'd2) begin
         $display("FAIL normal_cnt: got %0d want 2", beat_cnt);
         failures++;
      end
   endtask

   task automatic test_short();
      logic [7:0] e;
      short = 1'b1;
      for (int i = 0; i < 9; i++) begin
         e = exp_vec(1, (i % 3) + 1, (i % 3) == 2);
         asserts++;
         if (obs !== e || beat_cnt !== 4'(2 + i / 3)) begin
            $display("FAIL short cyc %0d: got %b cnt %0d want %b cnt %0d",
                     i, obs, beat_cnt, e, 2 + i / 3);
            failures++;
         end
         @(negedge clk);
      end
      short = 1'b0;
   endtask

   task automatic test_long();
      logic [7:0] e;
      long = 1'b1;
      for (int i = 0; i < 10; i++) begin
         e = exp_vec(i == 9 ? 1 : (i / 3) + 1, (i % 3) + 1, i == 8);
         asserts++;
         if (obs !== e) begin
            $display("FAIL long cyc %0d: got %b want %b", i, obs, e);
            failures++;
         end
         @(negedge clk);
      end
      long = 1'b0;
      // now at W1/t2 after one cycle of the next instruction
      asserts++;
      if (beat_cnt !== 4'd8) begin
         $display("FAIL long_cnt: got %0d want 8", beat_cnt);
         failures++;
      end
   endtask

   task automatic test_stop();
      logic [7:0] e;
      int bad;
      // W1/t2, W1/t3, then W2; stop only at W2/t3
      for (int i = 1; i < 6; i++) begin
         e = exp_vec(i < 3 ? 1 : 2, (i % 3) + 1, i == 5);
         asserts++;
         if (obs !== e) begin
            $display("FAIL stop_run cyc %0d: got %b want %b", i, obs, e);
            failures++;
         end
         if (i == 5) stop = 1'b1;
         @(negedge clk);
      end
      stop = 1'b0;
      bad = 0;
      for (int i = 0; i < 20; i++) begin
         if (obs !== 8'h00 || beat_cnt !== 4'd10) bad++;
         @(negedge clk);
      end
      asserts++;
      if (bad != 0) begin
         $display("FAIL stop_halted: got %0d bad cycles want 0", bad);
         failures++;
      end
      qd = 1'b1;
      repeat (2) @(negedge clk);
      asserts++;
      if (running !== 1'b0) begin
         $display("FAIL resume_early: got running=%b want 0", running);
         failures++;
      end
      @(negedge clk);
      asserts++;
      if (obs !== exp_vec(1, 1, 1'b0)) begin
         $display("FAIL resume_w1t1: got %b want %b", obs, exp_vec(1, 1, 1'b0));
         failures++;
      end
      // qd stays high; halt again at W2/t3 and make sure it does not restart
      repeat (5) @(negedge clk);
      stop = 1'b1;
      @(negedge clk);
      stop = 1'b0;
      bad = 0;
      for (int i = 0; i < 10; i++) begin
         if (running !== 1'b0) bad++;
         @(negedge clk);
      end
      asserts++;
      if (bad != 0 || beat_cnt !== 4'd12) begin
         $display("FAIL held_qd: got %0d running cycles cnt %0d want 0 cnt 12", bad, beat_cnt);
         failures++;
      end
      qd = 1'b0;
      repeat (4) @(negedge clk);
   endtask

   task automatic test_single();
      logic [7:0] e;
      single = 1'b1;
      // normal instruction: 12 -> 14
      qd = 1'b1;
      repeat (3) @(negedge clk);
      qd = 1'b0;
      for (int i = 0; i < 6; i++) begin
         e = exp_vec(i < 3 ? 1 : 2, (i % 3) + 1, i == 5);
         asserts++;
         if (obs !== e) begin
            $display("FAIL single_norm cyc %0d: got %b want %b", i, obs, e);
            failures++;
         end
         @(negedge clk);
      end
      asserts++;
      if (obs !== 8'h00 || beat_cnt !== 4'd14) begin
         $display("FAIL single_halt1: got %b cnt %0d want 00000000 cnt 14", obs, beat_cnt);
         failures++;
      end
      // short instruction: 14 -> 15
      repeat (3) @(negedge clk);
      short = 1'b1;
      qd = 1'b1;
      repeat (3) @(negedge clk);
      qd = 1'b0;
      repeat (3) @(negedge clk);
      short = 1'b0;
      asserts++;
      if (obs !== 8'h00 || beat_cnt !== 4'd15) begin
         $display("FAIL single_halt2: got %b cnt %0d want 00000000 cnt 15", obs, beat_cnt);
         failures++;
      end
      // long instruction: counter wraps 15 -> 0 -> 1 -> 2
      repeat (3) @(negedge clk);
      long = 1'b1;
      qd = 1'b1;
      repeat (3) @(negedge clk);
      qd = 1'b0;
      for (int i = 0; i < 9; i++) begin
         e = exp_vec((i / 3) + 1, (i % 3) + 1, i == 8);
         asserts++;
         if (obs !== e || beat_cnt !== 4'((15 + i / 3) % 16)) begin
            $display("FAIL single_long cyc %0d: got %b cnt %0d want %b cnt %0d",
                     i, obs, beat_cnt, e, (15 + i / 3) % 16);
            failures++;
         end
         @(negedge clk);
      end
      long = 1'b0;
      single = 1'b0;
      asserts++;
      if (obs !== 8'h00 || beat_cnt !== 4'd2) begin
         $display("FAIL single_wrap: got %b cnt %0d want 00000000 cnt 2", obs, beat_cnt);
         failures++;
      end
      repeat (3) @(negedge clk);
   endtask

   task automatic test_clr_midbeat();
      int bad;
      qd = 1'b1;
      repeat (3) @(negedge clk);
      qd = 1'b0;
      repeat (4) @(negedge clk);
      asserts++;
      if (obs !== exp_vec(2, 2, 1'b0)) begin
         $display("FAIL clr_pre_w2t2: got %b want %b", obs, exp_vec(2, 2, 1'b0));
         failures++;
      end
      clr = 1'b1;
      @(negedge clk);
      clr = 1'b0;
      asserts++;
      if (obs !== 8'h00 || beat_cnt !== 4'd0) begin
         $display("FAIL clr_abort: got %b cnt %0d want 00000000 cnt 0", obs, beat_cnt);
         failures++;
      end
      bad = 0;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         if (running !== 1'b0) bad++;
      end
      asserts++;
      if (bad != 0) begin
         $display("FAIL clr_stays_halted: got %0d running cycles want 0", bad);
         failures++;
      end
      qd = 1'b1;
      repeat (3) @(negedge clk);
      qd = 1'b0;
      asserts++;
      if (obs !== exp_vec(1, 1, 1'b0) || beat_cnt !== 4'd0) begin
         $display("FAIL clr_restart: got %b cnt %0d want %b cnt 0",
                  obs, beat_cnt, exp_vec(1, 1, 1'b0));
         failures++;
      end
   endtask

   initial begin
      #200000;
      $display("FAIL timeout: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      @(negedge clk);
      test_reset();
      test_normal();
      test_short();
      test_long();
      test_stop();
      test_single();
      test_clr_midbeat();
      $display("End of test - %0d assertions evaluated, %0d failures", asserts, failures);
      $finish;
   end

endmodule
